// File: rtl/fb_pkg.sv
// Shared framebuffer constants, draw-command opcodes and draw-engine state encoding.
// FB_WIDTH/FB_HEIGHT are also consumed by the VGA display side.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 40;
  localparam int unsigned FB_HEIGHT = 30;

  localparam logic [1:0] OP_PIXEL = 2'd0;
  localparam logic [1:0] OP_RECT  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } fb_state_t;

endpackage

// File: rtl/fb_clip.sv
// Combinational clip of a draw command to the framebuffer: yields the top-left corner,
// the exclusive right/bottom edges and an empty flag for commands that touch no pixel.
module fb_clip #(
  parameter int unsigned FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int unsigned COORD_W   = 10
) (
  input  logic [1:0]         op,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W:0]   x_end,
  output logic [COORD_W:0]   y_end,
  output logic               empty
);
  import fb_pkg::*;

  localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(FB_WIDTH);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(FB_HEIGHT);

  logic [COORD_W-1:0] bw;
  logic [COORD_W-1:0] bh;
  logic [COORD_W:0]   x_sum;
  logic [COORD_W:0]   y_sum;
  logic               bad_op;

  always_comb begin
    x0     = x;
    y0     = y;
    bw     = w;
    bh     = h;
    bad_op = 1'b0;
    case (op)
      OP_PIXEL: begin
        bw = COORD_W'(1);
        bh = COORD_W'(1);
      end
      OP_RECT:  bad_op = 1'b0;
      OP_CLEAR: begin
        x0 = '0;
        y0 = '0;
        bw = COORD_W'(FB_WIDTH);
        bh = COORD_W'(FB_HEIGHT);
      end
      default:  bad_op = 1'b1;
    endcase
    // One extra bit so x + w cannot wrap back inside the screen.
    x_sum = {1'b0, x0} + {1'b0, bw};
    y_sum = {1'b0, y0} + {1'b0, bh};
    x_end = (x_sum > X_LIM) ? X_LIM : x_sum;
    y_end = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    empty = bad_op || (bw == '0) || (bh == '0) ||
            ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
  end

endmodule

// File: rtl/fb_draw_engine.sv
// Framebuffer drawing engine: accepts PIXEL/RECT/CLEAR commands and emits a clipped,
// raster-order stream of single-pixel writes on the framebuffer write port.
module fb_draw_engine #(
  parameter int unsigned FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned ADDR_W    = 17
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [2:0]         cmd_color,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [2:0]         wr_data
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

  fb_state_t          state;
  logic [1:0]         op_q;
  logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
  logic [2:0]         color_q;

  logic [COORD_W-1:0] clip_x0, clip_y0;
  logic [COORD_W:0]   clip_x_end, clip_y_end;
  logic               clip_empty;

  logic [COORD_W-1:0] x_start;
  logic [COORD_W:0]   cur_x, cur_y, x_last, y_last;
  logic [ADDR_W-1:0]  row_base, setup_base;

  fb_clip #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT),
    .COORD_W  (COORD_W)
  ) u_clip (
    .op   (op_q),
    .x    (x_q),
    .y    (y_q),
    .w    (w_q),
    .h    (h_q),
    .x0   (clip_x0),
    .y0   (clip_y0),
    .x_end(clip_x_end),
    .y_end(clip_y_end),
    .empty(clip_empty)
  );

  // The only multiply: once per command, in SETUP.
  assign setup_base = ADDR_W'(clip_y0) * ROW_STEP;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      op_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      x_start   <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      x_last    <= '0;
      y_last    <= '0;
      row_base  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            x_q       <= cmd_x;
            y_q       <= cmd_y;
            w_q       <= cmd_w;
            h_q       <= cmd_h;
            color_q   <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          x_start  <= clip_x0;
          cur_x    <= {1'b0, clip_x0};
          cur_y    <= {1'b0, clip_y0};
          x_last   <= clip_x_end - (COORD_W+1)'(1);
          y_last   <= clip_y_end - (COORD_W+1)'(1);
          row_base <= setup_base;
          if (clip_empty) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= setup_base + ADDR_W'(clip_x0);
            wr_data <= color_q;
            state   <= ST_FILL;
          end
        end
        ST_FILL: begin
          // The outputs already hold the write at (cur_x, cur_y); pick the next one.
          if (cur_x != x_last) begin
            cur_x   <= cur_x + (COORD_W+1)'(1);
            wr_addr <= wr_addr + ADDR_W'(1);
          end else if (cur_y != y_last) begin
            cur_x    <= {1'b0, x_start};
            cur_y    <= cur_y + (COORD_W+1)'(1);
            row_base <= row_base + ROW_STEP;
            wr_addr  <= row_base + ROW_STEP + ADDR_W'(x_start);
          end else begin
            wr_en <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_draw_engine.sv
// Directed bench for fb_draw_engine: a reference model queues every expected write,
// and the write stream, latencies and handshake are checked as the engine runs.
module tb_fb_draw_engine;
  import fb_pkg::*;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int CW = 10;
  localparam int AW = 17;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [CW-1:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [2:0]    cmd_color = '0;
  logic          busy, done, wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;

  fb_draw_engine #(
    .FB_WIDTH (W),
    .FB_HEIGHT(H),
    .COORD_W  (CW),
    .ADDR_W   (AW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int vectors = 0;
  int errors  = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference model: enumerate the clipped box directly in raster order.
  function automatic int push_expected(input int op, input int x, input int y,
                                       input int w, input int h, input int color);
    int bx, by, bw, bh, xe, ye, n;
    n = 0;
    bx = x; by = y; bw = w; bh = h;
    if (op == 0) begin
      bw = 1; bh = 1;
    end else if (op == 2) begin
      bx = 0; by = 0; bw = W; bh = H;
    end else if (op != 1) begin
      return 0;
    end
    xe = (bx + bw > W) ? W : bx + bw;
    ye = (by + bh > H) ? H : by + bh;
    for (int yy = by; yy < ye; yy++)
      for (int xx = bx; xx < xe; xx++) begin
        exp_q.push_back({17'(yy * W + xx), 3'(color)});
        n++;
      end
    return n;
  endfunction

  task automatic drive(input logic [1:0] op, input int x, input int y,
                       input int w, input int h, input logic [2:0] color);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = CW'(x);
    cmd_y     = CW'(y);
    cmd_w     = CW'(w);
    cmd_h     = CW'(h);
    cmd_color = color;
  endtask

  // Returns on the negedge after the handshake cycle (the SETUP cycle).
  task automatic wait_accept(input string tag);
    int k;
    k = 0;
    while (!(cmd_ready && cmd_valid) && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check({tag, "/accept"}, 32'(cmd_ready), 32'd1);
    acc_cyc = cyc;
    @(negedge clock);
  endtask

  task automatic collect(input string tag, input int exp_n);
    int nwr, busy_n, ready_bad, gap_bad, last_wr;
    bit got_done;
    logic [19:0] e;
    nwr = 0; busy_n = 0; ready_bad = 0; gap_bad = 0; got_done = 1'b0;
    last_wr = acc_cyc + 1;
    for (int k = 0; k < 1400 && !got_done; k++) begin
      if (busy) busy_n++;
      if (cmd_ready) ready_bad++;
      if (wr_en) begin
        if (cyc != last_wr + 1) gap_bad++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({tag, "/addr"}, 32'(wr_addr), 32'(e[19:3]));
          check({tag, "/data"}, 32'(wr_data), 32'(e[2:0]));
        end
        last_wr = cyc;
        nwr++;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        @(negedge clock);
      end
    end
    check({tag, "/done_seen"}, 32'(got_done), 32'd1);
    check({tag, "/done_latency"}, 32'(done_cyc - last_wr), 32'd1);
    check({tag, "/write_count"}, 32'(nwr), 32'(exp_n));
    check({tag, "/busy_cycles"}, 32'(busy_n), 32'(exp_n + 2));
    check({tag, "/ready_while_busy"}, 32'(ready_bad), 32'd0);
    check({tag, "/write_gaps"}, 32'(gap_bad), 32'd0);
    check({tag, "/missing_writes"}, 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check({tag, "/ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, "/busy_after"}, 32'(busy), 32'd0);
    check({tag, "/done_after"}, 32'(done), 32'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input int x, input int y,
                     input int w, input int h, input logic [2:0] c, input int exp_n);
    int n;
    n = push_expected(int'(op), x, y, w, h, int'(c));
    drive(op, x, y, w, h, c);
    wait_accept(tag);
    cmd_valid = 1'b0;
    collect(tag, exp_n);
  endtask

  initial begin
    int n, seen, stray;
    logic [19:0] e;

    repeat (2) @(negedge clock);
    check("rst/cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/wr_en", 32'(wr_en), 32'd0);
    check("rst/wr_addr", 32'(wr_addr), 32'd0);
    check("rst/wr_data", 32'(wr_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run("clear5", OP_CLEAR, 7, 9, 3, 3, 3'b101, 1200);
    run("rect_corner", OP_RECT, 38, 28, 5, 5, 3'd2, 4);
    run("pixel", OP_PIXEL, 3, 2, 0, 0, 3'd7, 1);
    run("rect_offscreen", OP_RECT, 40, 0, 4, 4, 3'd3, 0);
    run("rect_w0", OP_RECT, 10, 10, 0, 5, 3'd3, 0);
    run("rect_h0", OP_RECT, 10, 10, 5, 0, 3'd3, 0);
    run("rect_below", OP_RECT, 0, 30, 2, 2, 3'd1, 0);
    run("reserved", 2'd3, 0, 0, 4, 4, 3'd6, 0);
    run("rect_mid", OP_RECT, 5, 3, 4, 3, 3'd3, 12);
    run("rect_nowrap", OP_RECT, 39, 29, 1023, 1023, 3'd4, 1);

    // Second command held valid for the whole CLEAR.
    n = push_expected(2, 0, 0, 0, 0, 1);
    drive(OP_CLEAR, 0, 0, 0, 0, 3'd1);
    wait_accept("hold_clear");
    drive(OP_RECT, 2, 1, 3, 2, 3'd6);
    collect("hold_clear", 1200);
    n = push_expected(1, 2, 1, 3, 2, 6);
    wait_accept("hold_rect");
    check("hold/accept_cycle", 32'(acc_cyc), 32'(done_cyc + 1));
    cmd_valid = 1'b0;
    collect("hold_rect", 6);

    // Reset during the 500th write of a CLEAR.
    n = push_expected(2, 0, 0, 0, 0, 5);
    drive(OP_CLEAR, 0, 0, 0, 0, 3'b101);
    wait_accept("rst_clear");
    cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 700 && seen < 500; k++) begin
      if (wr_en && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rst_clear/addr", 32'(wr_addr), 32'(e[19:3]));
        seen++;
      end
      if (seen < 500) @(negedge clock);
    end
    check("rst_clear/writes_before_reset", 32'(seen), 32'd500);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst/wr_en", 32'(wr_en), 32'd0);
    check("async_rst/cmd_ready", 32'(cmd_ready), 32'd1);
    check("async_rst/busy", 32'(busy), 32'd0);
    check("async_rst/done", 32'(done), 32'd0);
    check("async_rst/wr_addr", 32'(wr_addr), 32'd0);
    check("async_rst/wr_data", 32'(wr_data), 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clock);
      if (wr_en || busy || done) stray++;
    end
    check("post_rst/idle", 32'(stray), 32'd0);
    run("post_rst_pixel", OP_PIXEL, 20, 15, 9, 9, 3'd4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
